issue_scheduler: RTL

//  In-order dispatch controller between the issue FIFO head and NUM_FU functional units (FUs).

---
 rtl/ooo_pkg.sv | 19 +
 rtl/issue_scheduler_rr_arbiter.sv | 33 +++
 rtl/issue_scheduler.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/ooo_pkg.sv
// Purpose: shared widths and the drain FSM encoding for the issue path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ooo_pkg;

  localparam int NUM_FU_DEF      = 2;
  localparam int NUM_REG_DEF     = 8;
  localparam int REG_ID_BIT_DEF  = $clog2(NUM_REG_DEF);
  localparam int INST_ID_BIT_DEF = 8;
  localparam int IMM_BIT_DEF     = 4;
  localparam int STAT_BIT_DEF    = 16;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DRAINED = 2'd2
  } drain_state_e;

endpackage

// File: rtl/issue_scheduler_rr_arbiter.sv
// Purpose: round-robin pick of the first requester at or after ptr, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; gnt is all-zero when no request is raised.
// Ports: i_req (N requests), i_ptr (search start), o_gnt (one-hot), o_gnt_idx (index of o_gnt).
module rr_arbiter #(
  parameter int N     = 2,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic [PTR_W-1:0] o_gnt_idx
);

  logic w_found;
  int   w_idx;

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    w_found   = 1'b0;
    w_idx     = 0;
    for (int i = 0; i < N; i++) begin
      w_idx = (int'(i_ptr) + i) % N;
      if (!w_found && i_req[w_idx]) begin
        w_found          = 1'b1;
        o_gnt[w_idx]     = 1'b1;
        o_gnt_idx        = PTR_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/issue_scheduler.sv
// Purpose: in-order dispatch from the issue FIFO head to NUM_FU units with a RAW/WAW write-busy
//          scoreboard, round-robin FU grant and a drain FSM for flush / mode change.
// Latency: 0 cycles head -> fu_vld (combinational fire); scoreboard and rr pointer update next edge.
// Backpressure: head held (o_in_rdy=0) on hazard, no ready FU, or outside RUN.
// Ports: i_clk/i_rst (sync active-high); i_in_* head + o_in_rdy; i_fu_rdy/o_fu_vld one-hot strobe;
//        o_out_* broadcast fields; i_wb_vld/i_wb_reg writeback; i_drain_req/o_drained; o_busy.
// Optional: define ISSUE_STATS_EN to add saturating o_stat_issued / o_stat_stalled counters.
module issue_scheduler
  import ooo_pkg::*;
#(
  parameter int NUM_FU      = NUM_FU_DEF,
  parameter int INST_ID_BIT = INST_ID_BIT_DEF,
  parameter int NUM_REG     = NUM_REG_DEF,
  parameter int IMM_BIT     = IMM_BIT_DEF,
  parameter int REG_ID_BIT  = $clog2(NUM_REG)
`ifdef ISSUE_STATS_EN
  ,
  parameter int STAT_BIT    = STAT_BIT_DEF
`endif
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_in_vld,
  output logic                   o_in_rdy,
  input  logic [INST_ID_BIT-1:0] i_in_id,
  input  logic [REG_ID_BIT-1:0]  i_in_dst_reg,
  input  logic [REG_ID_BIT-1:0]  i_in_src_reg0,
  input  logic [REG_ID_BIT-1:0]  i_in_src_reg1,
  input  logic [IMM_BIT-1:0]     i_in_imm,
  input  logic [NUM_FU-1:0]      i_fu_rdy,
  output logic [NUM_FU-1:0]      o_fu_vld,
  output logic [INST_ID_BIT-1:0] o_out_id,
  output logic [REG_ID_BIT-1:0]  o_out_dst_reg,
  output logic [REG_ID_BIT-1:0]  o_out_src_reg0,
  output logic [REG_ID_BIT-1:0]  o_out_src_reg1,
  output logic [IMM_BIT-1:0]     o_out_imm,
  input  logic                   i_wb_vld,
  input  logic [REG_ID_BIT-1:0]  i_wb_reg,
  input  logic                   i_drain_req,
  output logic                   o_drained,
`ifdef ISSUE_STATS_EN
  output logic [STAT_BIT-1:0]    o_stat_issued,
  output logic [STAT_BIT-1:0]    o_stat_stalled,
`endif
  output logic [NUM_REG-1:0]     o_busy
);

  localparam int FU_PTR_BIT = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  drain_state_e          r_state;
  logic                  r_drained;
  logic [NUM_REG-1:0]    r_busy;
  logic [FU_PTR_BIT-1:0] r_rr_ptr;

  logic [NUM_FU-1:0]     w_gnt;
  logic [FU_PTR_BIT-1:0] w_gnt_idx;
  logic [FU_PTR_BIT-1:0] w_ptr_nxt;
  logic [NUM_REG-1:0]    w_clr_mask;
  logic [NUM_REG-1:0]    w_set_mask;
  logic [NUM_REG-1:0]    w_busy_nxt;
  logic                  w_hazard;
  logic                  w_run;
  logic                  w_fire;

  rr_arbiter #(
    .N     (NUM_FU),
    .PTR_W (FU_PTR_BIT)
  ) u_rr_arbiter (
    .i_req     (i_fu_rdy),
    .i_ptr     (r_rr_ptr),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx)
  );

  // Hazard looks only at the registered scoreboard: a writeback in this cycle
  // releases its dependents one cycle later, which keeps wb off the fire path.
  assign w_hazard = r_busy[i_in_src_reg0] | r_busy[i_in_src_reg1] | r_busy[i_in_dst_reg];

  // A drain request blocks dispatch in the very cycle it is raised, before the
  // FSM has left RUN, so nothing new becomes outstanding once drain is asked for.
  assign w_run  = (r_state == ST_RUN) & ~i_drain_req;
  assign w_fire = i_in_vld & ~w_hazard & (|i_fu_rdy) & w_run;

  assign o_in_rdy       = w_fire;
  assign o_fu_vld       = w_fire ? w_gnt : '0;
  assign o_out_id       = i_in_id;
  assign o_out_dst_reg  = i_in_dst_reg;
  assign o_out_src_reg0 = i_in_src_reg0;
  assign o_out_src_reg1 = i_in_src_reg1;
  assign o_out_imm      = i_in_imm;
  assign o_busy         = r_busy;
  assign o_drained      = r_drained;

  always_comb begin
    w_clr_mask = '0;
    w_set_mask = '0;
    if (i_wb_vld) w_clr_mask[i_wb_reg] = 1'b1;
    if (w_fire)   w_set_mask[i_in_dst_reg] = 1'b1;
  end

  // Clear before set: a new writer of the register being written back stays busy.
  assign w_busy_nxt = (r_busy & ~w_clr_mask) | w_set_mask;

  assign w_ptr_nxt = (w_gnt_idx == FU_PTR_BIT'(NUM_FU - 1)) ? '0 : w_gnt_idx + FU_PTR_BIT'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy   <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_fire) r_rr_ptr <= w_ptr_nxt;
    end
  end

  // Drain FSM. Reaching idle takes priority over a late drop of drain_req; the
  // FSM then passes through DRAINED for a cycle before returning to RUN.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_RUN;
      r_drained <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (i_drain_req) r_state <= ST_DRAIN;
          r_drained <= 1'b0;
        end
        ST_DRAIN: begin
          if (r_busy == '0) begin
            r_state   <= ST_DRAINED;
            r_drained <= 1'b1;
          end else if (!i_drain_req) begin
            r_state   <= ST_RUN;
          end
        end
        ST_DRAINED: begin
          if (!i_drain_req) begin
            r_state   <= ST_RUN;
            r_drained <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_RUN;
          r_drained <= 1'b0;
        end
      endcase
    end
  end

`ifdef ISSUE_STATS_EN
  logic [STAT_BIT-1:0] r_stat_issued;
  logic [STAT_BIT-1:0] r_stat_stalled;
  logic                w_stall;

  // A head held back for any reason while in RUN counts as a stall cycle,
  // including the cycle in which a drain request blocks it.
  assign w_stall = i_in_vld & ~w_fire & (r_state == ST_RUN);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stat_issued  <= '0;
      r_stat_stalled <= '0;
    end else begin
      if (w_fire && (r_stat_issued != '1))   r_stat_issued  <= r_stat_issued + STAT_BIT'(1);
      if (w_stall && (r_stat_stalled != '1)) r_stat_stalled <= r_stat_stalled + STAT_BIT'(1);
    end
  end

  assign o_stat_issued  = r_stat_issued;
  assign o_stat_stalled = r_stat_stalled;
`endif

endmodule
